dff_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) FIFO, N bits wide and DEPTH entries deep, built from the library register primitives.
- Decouples a producer that writes registers from a consumer that reads them.
- Used for buffering between CPU datapath stages and for MMIO peripheral queues.
- The write side pushes with WE; the read side sees the head word on Q and pops with RE.

---
 rtl/dff_fifo_pkg.sv | 11 +
 rtl/dff_fifo_ctl.sv | 54 +++++
 rtl/dff_reg.sv | 22 ++
 rtl/dff_fifo.sv | 67 ++++++
 tb/tb_dff_fifo.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/dff_fifo_pkg.sv
// Shared helpers for the dff_fifo codebase slice.
// Contents: pointer increment with modulo-depth wrap.
package dff_fifo_pkg;

  // Next value of a ring pointer; wraps from depth-1 back to 0.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dff_fifo_ctl.sv
// Control path of dff_fifo: ring pointers, occupancy count, sticky error flags.
// Ports: C clock, R sync active-low reset, WE/RE push/pop requests,
//        wp/rp ring pointers, cnt occupancy, EMPTY/FULL decodes of cnt,
//        OVF/UDF sticky flags, push_ok accepted-write strobe for storage.
module dff_fifo_ctl
  import dff_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     C,
  input  logic                     R,
  input  logic                     WE,
  input  logic                     RE,
  output logic [$clog2(DEPTH)-1:0] wp,
  output logic [$clog2(DEPTH)-1:0] rp,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     OVF,
  output logic                     UDF,
  output logic                     push_ok
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic pop_ok;

  // cnt is the sole authority for full/empty; pointers are never compared.
  always_comb begin
    EMPTY   = (cnt == '0);
    FULL    = (cnt == CW'(DEPTH));
    pop_ok  = RE & ~EMPTY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
    push_ok = WE & (~FULL | RE);
  end

  always_ff @(posedge C) begin
    if (!R) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (push_ok) wp <= AW'(ptr_next(32'(wp), DEPTH));
      if (pop_ok)  rp <= AW'(ptr_next(32'(rp), DEPTH));
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      if (WE & ~push_ok) OVF <= 1'b1;
      if (RE & EMPTY)    UDF <= 1'b1;
    end
  end

endmodule

// File: rtl/dff_reg.sv
// Library N-bit register with synchronous active-high reset and clock enable.
// Ports: C clock, R sync reset (1 = load INIT), CE load enable, D data in, Q data out.
module dff_reg #(
  parameter int unsigned   N    = 8,
  parameter logic [N-1:0]  INIT = '0
) (
  input  logic         C,
  input  logic         R,
  input  logic         CE,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  always_ff @(posedge C) begin
    if (R) begin
      Q <= INIT;
    end else if (CE) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/dff_fifo.sv
// First-word-fall-through FIFO built from library registers.
// Ports: C clock, R sync active-low reset, D write data, WE push, RE pop,
//        Q head word (valid when EMPTY=0), EMPTY, FULL, COUNT occupancy,
//        OVF/UDF sticky overflow/underflow flags (cleared only by reset).
module dff_fifo
  import dff_fifo_pkg::*;
#(
  parameter int unsigned  N     = 8,
  parameter int unsigned  DEPTH = 4,
  parameter logic [N-1:0] INIT  = '0
) (
  input  logic                   C,
  input  logic                   R,
  input  logic [N-1:0]           D,
  input  logic                   WE,
  input  logic                   RE,
  output logic [N-1:0]           Q,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  output logic                   UDF
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic [N-1:0]  entries [DEPTH];

  dff_fifo_ctl #(
    .DEPTH(DEPTH)
  ) u_ctl (
    .C      (C),
    .R      (R),
    .WE     (WE),
    .RE     (RE),
    .wp     (wp),
    .rp     (rp),
    .cnt    (COUNT),
    .EMPTY  (EMPTY),
    .FULL   (FULL),
    .OVF    (OVF),
    .UDF    (UDF),
    .push_ok(push_ok)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    dff_reg #(
      .N   (N),
      .INIT(INIT)
    ) u_reg (
      .C (C),
      .R (~R),
      .CE(push_ok & (wp == AW'(i))),
      .D (D),
      .Q (entries[i])
    );
  end

  // Head word straight from storage: zero read latency.
  always_comb begin
    Q = entries[rp];
  end

endmodule

// File: tb/tb_dff_fifo.sv
module tb_dff_fifo;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic         C = 1'b0;
  logic         R = 1'b0;
  logic [N-1:0] D = '0;
  logic         WE = 1'b0;
  logic         RE = 1'b0;
  logic [N-1:0] Q;
  logic         EMPTY;
  logic         FULL;
  logic [2:0]   COUNT;
  logic         OVF;
  logic         UDF;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of stored words plus two sticky bits.
  logic [N-1:0] mq[$];
  bit           movf = 0;
  bit           mudf = 0;

  dff_fifo #(
    .N    (N),
    .DEPTH(DEPTH),
    .INIT (8'h00)
  ) dut (
    .C    (C),
    .R    (R),
    .D    (D),
    .WE   (WE),
    .RE   (RE),
    .Q    (Q),
    .EMPTY(EMPTY),
    .FULL (FULL),
    .COUNT(COUNT),
    .OVF  (OVF),
    .UDF  (UDF)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rr, input bit we, input bit re, input logic [N-1:0] d);
    bit emp, ful, pop, push;
    if (!rr) begin
      mq.delete();
      movf = 0;
      mudf = 0;
    end else begin
      emp  = (mq.size() == 0);
      ful  = (mq.size() == DEPTH);
      pop  = re && !emp;
      push = we && (!ful || re);
      if (re && emp) mudf = 1;
      if (we && !push) movf = 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(COUNT), 32'(mq.size()));
    check({tag, ".empty"}, 32'(EMPTY), 32'(mq.size() == 0));
    check({tag, ".full"},  32'(FULL),  32'(mq.size() == DEPTH));
    check({tag, ".ovf"},   32'(OVF),   32'(movf));
    check({tag, ".udf"},   32'(UDF),   32'(mudf));
    if (mq.size() != 0) check({tag, ".q"}, 32'(Q), 32'(mq[0]));
  endtask

  // One clock: drive inputs, take the edge, update model, sample 1 time unit later.
  task automatic step(input bit rr, input bit we, input bit re, input logic [N-1:0] d,
                      input string tag);
    R = rr; WE = we; RE = re; D = d;
    @(posedge C);
    model_edge(rr, we, re, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    #1;
    // 1. reset dominates WE/RE
    step(0, 1, 1, 8'hFF, "rst0");
    step(0, 1, 1, 8'hFF, "rst1");
    check("rst.q", 32'(Q), 32'h00);
    check("rst.count", 32'(COUNT), 0);

    // 2. fill and drain
    step(1, 1, 0, 8'h11, "fill");
    step(1, 1, 0, 8'h22, "fill");
    step(1, 1, 0, 8'h33, "fill");
    step(1, 1, 0, 8'h44, "fill");
    check("fill.full", 32'(FULL), 1);
    check("fill.q", 32'(Q), 32'h11);
    step(1, 0, 1, 8'h00, "drain"); check("drain.q1", 32'(Q), 32'h22);
    step(1, 0, 1, 8'h00, "drain"); check("drain.q2", 32'(Q), 32'h33);
    step(1, 0, 1, 8'h00, "drain"); check("drain.q3", 32'(Q), 32'h44);
    step(1, 0, 1, 8'h00, "drain"); check("drain.empty", 32'(EMPTY), 1);

    // 3. overflow
    step(0, 0, 0, 8'h00, "rst");
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 8'(8'h11 * i), "ovfill");
    step(1, 1, 0, 8'h55, "ovf");
    check("ovf.count", 32'(COUNT), 4);
    check("ovf.flag", 32'(OVF), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf.drain", 32'(Q), 32'(8'(8'h11 * i)));
      step(1, 0, 1, 8'h00, "ovdrain");
    end
    check("ovf.sticky", 32'(OVF), 1);

    // 4. full with simultaneous push and pop
    step(0, 0, 0, 8'h00, "rst");
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 8'(8'h11 * i), "fpfill");
    step(1, 1, 1, 8'h66, "fpp");
    check("fpp.count", 32'(COUNT), 4);
    check("fpp.q", 32'(Q), 32'h22);
    check("fpp.ovf", 32'(OVF), 0);
    step(1, 0, 1, 8'h00, "fpd"); check("fpp.d1", 32'(Q), 32'h33);
    step(1, 0, 1, 8'h00, "fpd"); check("fpp.d2", 32'(Q), 32'h44);
    step(1, 0, 1, 8'h00, "fpd"); check("fpp.d3", 32'(Q), 32'h66);
    step(1, 0, 1, 8'h00, "fpd");

    // 5. empty-side underflow cases
    step(0, 0, 0, 8'h00, "rst");
    step(1, 0, 1, 8'h00, "udf");
    check("udf.flag", 32'(UDF), 1);
    check("udf.count", 32'(COUNT), 0);
    step(0, 0, 0, 8'h00, "rst");
    step(1, 1, 1, 8'h77, "epp");
    check("epp.udf", 32'(UDF), 1);
    check("epp.count", 32'(COUNT), 1);
    check("epp.q", 32'(Q), 32'h77);

    // 6. pointer wrap with alternating push/pop, then mid-operation reset
    step(0, 0, 0, 8'h00, "rst");
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'(8'h80 + i), "wrap.push");
      check("wrap.q", 32'(Q), 32'(8'(8'h80 + i)));
      step(1, 0, 1, 8'h00, "wrap.pop");
      check("wrap.cnt", 32'(COUNT <= 1), 1);
    end
    step(1, 1, 0, 8'hA1, "pre");
    step(1, 1, 0, 8'hA2, "pre");
    step(1, 1, 0, 8'hA3, "pre");
    step(0, 0, 0, 8'h00, "midrst");
    check("midrst.q", 32'(Q), 32'h00);
    check("midrst.empty", 32'(EMPTY), 1);

    // Randomized traffic against the queue model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
           8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
